// File: rtl/prio_encoder_32x5.sv
// -----------------------------------------------------------------------------
// prio_encoder_32x5
//
// Registered 32-to-5 priority encoder with sticky request capture and an
// acknowledge handshake. Inverse companion of the 5x32 line decoder; used for
// interrupt and request dispatch in the datapath.
//
// Single-cycle request pulses are latched into a pending register. Each rising
// edge picks the highest-priority unmasked pending line and presents it as a
// 5-bit index with a valid flag. When the consumer acknowledges, the presented
// line's pending bit is cleared on that same edge, and the next winner is
// already visible after the edge.
//
// Parameters
//   LOW_FIRST  1: index 0 has highest priority; 0: index 31 has highest priority
//
// Ports
//   CLK    in   1   clock, all state updates on the rising edge
//   RESET  in   1   asynchronous active-low reset, clears all state while 0
//   REQ    in  32   request pulses; bit i high at an edge sets pending bit i
//   MASK   in  32   bit i high makes line i ineligible (pending bit is kept)
//   ACK    in   1   consumer has taken the currently presented IDX
//   IDX    out  5   index of the selected line (registered)
//   VALID  out  1   IDX is meaningful (registered)
//   PEND   out 32   current pending register (registered, status/debug)
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module prio_encoder_32x5 #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] REQ,
    input  logic [31:0] MASK,
    input  logic        ACK,
    output logic [4:0]  IDX,
    output logic        VALID,
    output logic [31:0] PEND
);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // One-hot decode of a 5-bit index into a 32-bit line vector.
    function automatic logic [31:0] one_hot(input logic [4:0] idx);
        logic [31:0] r;
        r      = 32'd0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty. Scanning from
    // the top down lets the last assignment (the lowest bit) win.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                r = 5'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Index of the highest set bit; 0 when the vector is empty. Scanning from
    // the bottom up lets the last assignment (the highest bit) win.
    function automatic logic [4:0] highest_set(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i <= 31; i++) begin
            if (v[i]) begin
                r = 5'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] pend_r;
    logic [4:0]  idx_r;
    logic        valid_r;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic [31:0] clr_s;        // line being served this edge (one-hot or zero)
    logic [31:0] pend_next_s;  // pending vector after clear and new requests
    logic [31:0] elig_s;       // pending lines not masked this edge
    logic        any_s;        // at least one eligible line
    logic [4:0]  win_s;        // index of the priority winner among elig_s

    // Served-line clear: only a valid presentation can be acknowledged.
    always_comb begin
        clr_s = 32'd0;
        if (ACK && valid_r) begin
            clr_s = one_hot(idx_r);
        end else begin
            clr_s = 32'd0;
        end
    end

    // Pending update and eligibility. The OR with REQ comes after the clear so
    // a request arriving on the edge that serves the same line keeps it pending.
    always_comb begin
        pend_next_s = (pend_r & ~clr_s) | REQ;
        elig_s      = pend_next_s & ~MASK;
        any_s       = |elig_s;
    end

    // Priority selection; both scanners return 0 for an empty vector, which
    // gives IDX=0 whenever nothing is eligible.
    always_comb begin
        win_s = 5'd0;
        if (LOW_FIRST) begin
            win_s = lowest_set(elig_s);
        end else begin
            win_s = highest_set(elig_s);
        end
    end

    // State registers: pending vector, presented index and valid flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_r  <= 32'd0;
            idx_r   <= 5'd0;
            valid_r <= 1'b0;
        end else begin
            pend_r  <= pend_next_s;
            idx_r   <= win_s;
            valid_r <= any_s;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (direct flop outputs)
    // -------------------------------------------------------------------------
    assign IDX   = idx_r;
    assign VALID = valid_r;
    assign PEND  = pend_r;

endmodule

// File: tb/tb_prio_encoder_32x5.sv
// -----------------------------------------------------------------------------
// tb_prio_encoder_32x5
//
// Directed self-checking bench for prio_encoder_32x5. Two instances share the
// same stimulus: dut_lo (LOW_FIRST=1) and dut_hi (LOW_FIRST=0). Inputs change
// 1 time unit after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_prio_encoder_32x5;

    logic        CLK;
    logic        RESET;
    logic [31:0] REQ;
    logic [31:0] MASK;
    logic        ACK;

    logic [4:0]  idx_lo;
    logic        valid_lo;
    logic [31:0] pend_lo;
    logic [4:0]  idx_hi;
    logic        valid_hi;
    logic [31:0] pend_hi;

    int n_cmp;
    int n_err;

    prio_encoder_32x5 #(.LOW_FIRST(1'b1)) dut_lo (
        .CLK   (CLK),
        .RESET (RESET),
        .REQ   (REQ),
        .MASK  (MASK),
        .ACK   (ACK),
        .IDX   (idx_lo),
        .VALID (valid_lo),
        .PEND  (pend_lo)
    );

    prio_encoder_32x5 #(.LOW_FIRST(1'b0)) dut_hi (
        .CLK   (CLK),
        .RESET (RESET),
        .REQ   (REQ),
        .MASK  (MASK),
        .ACK   (ACK),
        .IDX   (idx_hi),
        .VALID (valid_hi),
        .PEND  (pend_hi)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge to a safe sampling/driving point.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RESET = 1'b0;
        REQ   = 32'd0;
        MASK  = 32'd0;
        ACK   = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_pend", pend_lo, 32'd0);
        chk("rst_valid", {31'd0, valid_lo}, 32'd0);
        chk("rst_idx", {27'd0, idx_lo}, 32'd0);
        RESET = 1'b1;

        // ---------------- async reset with full pending ----------------
        REQ = 32'hFFFF_FFFF;
        step();
        REQ = 32'd0;
        chk("fill_pend", pend_lo, 32'hFFFF_FFFF);
        chk("fill_valid", {31'd0, valid_lo}, 32'd1);
        chk("fill_idx_lo", {27'd0, idx_lo}, 32'd0);
        chk("fill_idx_hi", {27'd0, idx_hi}, 32'd31);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_pend", pend_lo, 32'd0);
        chk("async_valid", {31'd0, valid_lo}, 32'd0);
        chk("async_idx_hi", {27'd0, idx_hi}, 32'd0);
        #1;
        RESET = 1'b1;
        step();
        chk("post_rst_valid", {31'd0, valid_lo}, 32'd0);
        chk("post_rst_pend", pend_lo, 32'd0);

        // ---------------- fixed priority, both orders ----------------
        REQ = 32'h8000_0110;
        step();
        REQ = 32'd0;
        ACK = 1'b1;
        chk("fp_idx_lo_0", {27'd0, idx_lo}, 32'd4);
        chk("fp_idx_hi_0", {27'd0, idx_hi}, 32'd31);
        chk("fp_pend_0", pend_lo, 32'h8000_0110);
        step();
        chk("fp_idx_lo_1", {27'd0, idx_lo}, 32'd8);
        chk("fp_idx_hi_1", {27'd0, idx_hi}, 32'd8);
        chk("fp_pend_lo_1", pend_lo, 32'h8000_0100);
        step();
        chk("fp_idx_lo_2", {27'd0, idx_lo}, 32'd31);
        chk("fp_idx_hi_2", {27'd0, idx_hi}, 32'd4);
        chk("fp_valid_2", {31'd0, valid_lo}, 32'd1);
        step();
        ACK = 1'b0;
        chk("fp_valid_lo_end", {31'd0, valid_lo}, 32'd0);
        chk("fp_valid_hi_end", {31'd0, valid_hi}, 32'd0);
        chk("fp_pend_lo_end", pend_lo, 32'd0);
        chk("fp_pend_hi_end", pend_hi, 32'd0);
        chk("fp_idx_lo_end", {27'd0, idx_lo}, 32'd0);

        // ---------------- set beats clear ----------------
        REQ = 32'h0000_0020;
        step();
        chk("sbc_idx_0", {27'd0, idx_lo}, 32'd5);
        ACK = 1'b1;
        step();
        REQ = 32'd0;
        chk("sbc_pend", pend_lo, 32'h0000_0020);
        chk("sbc_valid", {31'd0, valid_lo}, 32'd1);
        chk("sbc_idx", {27'd0, idx_lo}, 32'd5);
        step();
        ACK = 1'b0;
        chk("sbc_drain_valid", {31'd0, valid_lo}, 32'd0);
        chk("sbc_drain_pend", pend_lo, 32'd0);

        // ---------------- mask and pre-emption ----------------
        MASK = 32'h0000_0002;
        REQ  = 32'h0000_0402;
        step();
        REQ = 32'd0;
        chk("msk_idx", {27'd0, idx_lo}, 32'd10);
        chk("msk_pend", pend_lo, 32'h0000_0402);
        // Mask drop must not reach the outputs before the next edge.
        MASK = 32'd0;
        #2;
        chk("msk_no_comb", {27'd0, idx_lo}, 32'd10);
        step();
        chk("msk_drop_idx", {27'd0, idx_lo}, 32'd1);
        ACK = 1'b1;
        step();
        chk("msk_ack1_idx", {27'd0, idx_lo}, 32'd10);
        chk("msk_ack1_pend", pend_lo, 32'h0000_0400);
        step();
        ACK = 1'b0;
        chk("msk_ack2_valid", {31'd0, valid_lo}, 32'd0);

        // Higher-priority arrival replaces IDX without ACK.
        REQ = 32'h0000_0100;
        step();
        REQ = 32'h0000_0004;
        chk("pre_idx_0", {27'd0, idx_lo}, 32'd8);
        step();
        REQ = 32'd0;
        chk("pre_idx_1", {27'd0, idx_lo}, 32'd2);
        chk("pre_idx_hi_1", {27'd0, idx_hi}, 32'd8);
        ACK = 1'b1;
        step();
        chk("pre_idx_2", {27'd0, idx_lo}, 32'd8);
        step();
        ACK = 1'b0;
        chk("pre_valid_end", {31'd0, valid_lo}, 32'd0);
        chk("pre_pend_hi_end", pend_hi, 32'd0);

        // ---------------- full drain ----------------
        REQ = 32'hFFFF_FFFF;
        step();
        REQ = 32'd0;
        ACK = 1'b1;
        chk("full_idx_lo_0", {27'd0, idx_lo}, 32'd0);
        chk("full_idx_hi_0", {27'd0, idx_hi}, 32'd31);
        for (int k = 1; k <= 31; k++) begin
            step();
            chk($sformatf("full_idx_lo_%0d", k), {27'd0, idx_lo}, 32'(k));
            chk($sformatf("full_idx_hi_%0d", k), {27'd0, idx_hi}, 32'(31 - k));
            chk($sformatf("full_pend_lo_%0d", k), pend_lo, 32'hFFFF_FFFF << k);
            chk($sformatf("full_valid_%0d", k), {31'd0, valid_lo}, 32'd1);
        end
        step();
        chk("full_valid_end", {31'd0, valid_lo}, 32'd0);
        chk("full_pend_end", pend_lo, 32'd0);
        chk("full_valid_hi_end", {31'd0, valid_hi}, 32'd0);
        // Spurious ACK with nothing valid.
        step();
        step();
        ACK = 1'b0;
        chk("spur_pend", pend_lo, 32'd0);
        chk("spur_idx", {27'd0, idx_lo}, 32'd0);
        chk("spur_valid", {31'd0, valid_lo}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
